regfile: RTL and testbench

REGFILE -- requirements
Module: regfile

---
 rtl/regfile.sv | 62 ++++++
 tb/tb_regfile.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// Two-read, one-write register file with register 0 hardwired to zero,
// same-cycle write-through bypass on both read ports, and a registered write-busy flag.
module regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic              wr_busy
);

  logic [DATA_W-1:0] mem [NREG];
  logic              wr_accept;

  assign wr_accept = we && (waddr != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem     <= '{default: '0};
      wr_busy <= 1'b0;
    end else begin
      wr_busy <= wr_accept;
      if (wr_accept) begin
        mem[waddr] <= wdata;
      end
    end
  end

  // Bypass is checked ahead of storage so a read in the write cycle sees the new value.
  always_comb begin
    rdata1 = '0;
    if (rst && re1 && (raddr1 != '0)) begin
      if (we && (waddr == raddr1)) begin
        rdata1 = wdata;
      end else begin
        rdata1 = mem[raddr1];
      end
    end
  end

  always_comb begin
    rdata2 = '0;
    if (rst && re2 && (raddr2 != '0)) begin
      if (we && (waddr == raddr2)) begin
        rdata2 = wdata;
      end else begin
        rdata2 = mem[raddr2];
      end
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus a randomized run,
// with expected {rdata1, rdata2, wr_busy} queued at drive time and popped when sampled.
module tb_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic        wr_busy;

  typedef struct packed {
    logic [31:0] r1;
    logic [31:0] r2;
    logic        b;
  } exp_t;

  exp_t        sb[$];
  exp_t        got;
  exp_t        e;
  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] mem_m [32];
  logic        busy_m;

  regfile #(.DATA_W(32), .ADDR_W(5), .NREG(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .re1     (re1),
    .raddr1  (raddr1),
    .rdata1  (rdata1),
    .re2     (re2),
    .raddr2  (raddr2),
    .rdata2  (rdata2),
    .wr_busy (wr_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  function automatic logic [31:0] rd(input logic re, input logic [4:0] a);
    if (!rst || !re || a == 5'd0) return 32'h0;
    if (we && waddr == a) return wdata;
    return mem_m[a];
  endfunction

  function automatic exp_t model_exp();
    exp_t x;
    x.r1 = rd(re1, raddr1);
    x.r2 = rd(re2, raddr2);
    x.b  = busy_m;
    return x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem_m[i] = 32'h0;
    busy_m = 1'b0;
  endtask

  // Advance one rising edge (updating the model), return on the following falling edge.
  task automatic cyc();
    @(posedge clk);
    if (rst && we && waddr != 5'd0) mem_m[waddr] = wdata;
    busy_m = rst && we && (waddr != 5'd0);
    @(negedge clk);
  endtask

  task automatic test_reset();
    re1 = 1; re2 = 1; raddr1 = 5'd3; raddr2 = 5'd4;
    we = 1; waddr = 5'd3; wdata = 32'hCAFEF00D;
    sb.push_back('{32'h0, 32'h0, 1'b0});
    #1; got = {rdata1, rdata2, wr_busy}; e = sb.pop_front(); n_chk++;
    if (got !== e) $display("FAIL reset_no_edge: got %h %h %b, required %h %h %b", got.r1, got.r2, got.b, e.r1, e.r2, e.b);
    else n_pass++;
    @(negedge clk); @(negedge clk);
    sb.push_back('{32'h0, 32'h0, 1'b0});
    #1; got = {rdata1, rdata2, wr_busy}; e = sb.pop_front(); n_chk++;
    if (got !== e) $display("FAIL reset_held_edges: got %h %h %b, required %h %h %b", got.r1, got.r2, got.b, e.r1, e.r2, e.b);
    else n_pass++;
    we = 0; rst = 1;
    for (int i = 1; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(32 - i);
      sb.push_back('{32'h0, 32'h0, 1'b0});
      #1; got = {rdata1, rdata2, wr_busy}; e = sb.pop_front(); n_chk++;
      if (got !== e) $display("FAIL reset_clear r%0d: got %h %h %b, required %h %h %b", i, got.r1, got.r2, got.b, e.r1, e.r2, e.b);
      else n_pass++;
      cyc();
    end
  endtask

  task automatic test_write_read();
    we = 1; waddr = 5'd5; wdata = 32'hDEADBEEF; re1 = 0; re2 = 0;
    cyc();
    we = 0; wdata = 32'h0; re1 = 1; raddr1 = 5'd5;
    sb.push_back('{32'hDEADBEEF, 32'h0, 1'b1});
    #1; got = {rdata1, rdata2, wr_busy}; e = sb.pop_front(); n_chk++;
    if (got !== e) $display("FAIL write_read: got %h %h %b, required %h %h %b", got.r1, got.r2, got.b, e.r1, e.r2, e.b);
    else n_pass++;
    cyc();
    sb.push_back('{32'hDEADBEEF, 32'h0, 1'b0});
    #1; got = {rdata1, rdata2, wr_busy}; e = sb.pop_front(); n_chk++;
    if (got !== e) $display("FAIL busy_one_cycle: got %h %h %b, required %h %h %b", got.r1, got.r2, got.b, e.r1, e.r2, e.b);
    else n_pass++;
  endtask

  task automatic test_bypass();
    we = 1; waddr = 5'd7; wdata = 32'h12345678;
    re1 = 1; re2 = 1; raddr1 = 5'd7; raddr2 = 5'd7;
    sb.push_back('{32'h12345678, 32'h12345678, 1'b0});
    #1; got = {rdata1, rdata2, wr_busy}; e = sb.pop_front(); n_chk++;
    if (got !== e) $display("FAIL bypass: got %h %h %b, required %h %h %b", got.r1, got.r2, got.b, e.r1, e.r2, e.b);
    else n_pass++;
    cyc();
    we = 0; waddr = 5'd8; wdata = 32'h0BADF00D;
    sb.push_back('{32'h12345678, 32'h12345678, 1'b1});
    #1; got = {rdata1, rdata2, wr_busy}; e = sb.pop_front(); n_chk++;
    if (got !== e) $display("FAIL read_after_bypass: got %h %h %b, required %h %h %b", got.r1, got.r2, got.b, e.r1, e.r2, e.b);
    else n_pass++;
    cyc();
  endtask

  task automatic test_zero_reg();
    we = 1; waddr = 5'd1; wdata = 32'h11; re1 = 0; re2 = 0;
    cyc();
    we = 1; waddr = 5'd0; wdata = 32'hFFFFFFFF; re1 = 1; raddr1 = 5'd0;
    sb.push_back('{32'h0, 32'h0, 1'b1});
    #1; got = {rdata1, rdata2, wr_busy}; e = sb.pop_front(); n_chk++;
    if (got !== e) $display("FAIL zero_reg_write_cycle: got %h %h %b, required %h %h %b", got.r1, got.r2, got.b, e.r1, e.r2, e.b);
    else n_pass++;
    cyc();
    we = 0;
    sb.push_back('{32'h0, 32'h0, 1'b0});
    #1; got = {rdata1, rdata2, wr_busy}; e = sb.pop_front(); n_chk++;
    if (got !== e) $display("FAIL zero_reg_after: got %h %h %b, required %h %h %b", got.r1, got.r2, got.b, e.r1, e.r2, e.b);
    else n_pass++;
  endtask

  task automatic test_read_disable();
    we = 1; waddr = 5'd3; wdata = 32'hA5A5A5A5; re1 = 0; re2 = 0;
    cyc();
    we = 0; re1 = 1; raddr1 = 5'd3; re2 = 0; raddr2 = 5'd3;
    sb.push_back('{32'hA5A5A5A5, 32'h0, 1'b1});
    #1; got = {rdata1, rdata2, wr_busy}; e = sb.pop_front(); n_chk++;
    if (got !== e) $display("FAIL read_disabled: got %h %h %b, required %h %h %b", got.r1, got.r2, got.b, e.r1, e.r2, e.b);
    else n_pass++;
    re2 = 1;
    sb.push_back('{32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1});
    #1; got = {rdata1, rdata2, wr_busy}; e = sb.pop_front(); n_chk++;
    if (got !== e) $display("FAIL read_enabled: got %h %h %b, required %h %h %b", got.r1, got.r2, got.b, e.r1, e.r2, e.b);
    else n_pass++;
    cyc();
  endtask

  task automatic test_back_to_back();
    re1 = 0; re2 = 0; we = 1; waddr = 5'd12;
    for (int i = 1; i <= 3; i++) begin
      wdata = 32'(i) * 32'h01010101;
      cyc();
    end
    we = 0; re1 = 1; raddr1 = 5'd12; re2 = 1; raddr2 = 5'd5;
    sb.push_back('{32'h03030303, 32'hDEADBEEF, 1'b1});
    #1; got = {rdata1, rdata2, wr_busy}; e = sb.pop_front(); n_chk++;
    if (got !== e) $display("FAIL back_to_back: got %h %h %b, required %h %h %b", got.r1, got.r2, got.b, e.r1, e.r2, e.b);
    else n_pass++;
    cyc();
  endtask

  task automatic test_reset_mid_write();
    we = 1; waddr = 5'd9; wdata = 32'h1; re1 = 0; re2 = 0;
    cyc();
    wdata = 32'h2; re1 = 1; raddr1 = 5'd9; re2 = 1; raddr2 = 5'd5;
    sb.push_back('{32'h2, 32'hDEADBEEF, 1'b1});
    #1; got = {rdata1, rdata2, wr_busy}; e = sb.pop_front(); n_chk++;
    if (got !== e) $display("FAIL pre_reset_bypass: got %h %h %b, required %h %h %b", got.r1, got.r2, got.b, e.r1, e.r2, e.b);
    else n_pass++;
    rst = 0;
    model_reset();
    sb.push_back('{32'h0, 32'h0, 1'b0});
    #1; got = {rdata1, rdata2, wr_busy}; e = sb.pop_front(); n_chk++;
    if (got !== e) $display("FAIL async_clear: got %h %h %b, required %h %h %b", got.r1, got.r2, got.b, e.r1, e.r2, e.b);
    else n_pass++;
    we = 0; rst = 1;
    sb.push_back('{32'h0, 32'h0, 1'b0});
    #1; got = {rdata1, rdata2, wr_busy}; e = sb.pop_front(); n_chk++;
    if (got !== e) $display("FAIL lost_write: got %h %h %b, required %h %h %b", got.r1, got.r2, got.b, e.r1, e.r2, e.b);
    else n_pass++;
    we = 1; wdata = 32'h33; re1 = 0;
    cyc();
    we = 0; re1 = 1;
    sb.push_back('{32'h33, 32'h0, 1'b1});
    #1; got = {rdata1, rdata2, wr_busy}; e = sb.pop_front(); n_chk++;
    if (got !== e) $display("FAIL first_write_after_reset: got %h %h %b, required %h %h %b", got.r1, got.r2, got.b, e.r1, e.r2, e.b);
    else n_pass++;
    cyc();
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      we     = ($urandom_range(0, 3) != 0);
      waddr  = 5'($urandom_range(0, 31));
      wdata  = $urandom;
      re1    = ($urandom_range(0, 4) != 0);
      re2    = ($urandom_range(0, 4) != 0);
      raddr1 = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom_range(0, 31));
      raddr2 = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom_range(0, 31));
      sb.push_back(model_exp());
      #1; got = {rdata1, rdata2, wr_busy}; e = sb.pop_front(); n_chk++;
      if (got !== e) $display("FAIL random[%0d] we=%b wa=%0d ra1=%0d ra2=%0d: got %h %h %b, required %h %h %b", i, we, waddr, raddr1, raddr2, got.r1, got.r2, got.b, e.r1, e.r2, e.b);
      else n_pass++;
      cyc();
    end
  endtask

  initial begin
    rst = 1; we = 0; waddr = '0; wdata = '0;
    re1 = 0; raddr1 = '0; re2 = 0; raddr2 = '0;
    model_reset();
    #1 rst = 0;
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_read_disable();
    test_back_to_back();
    test_reset_mid_write();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
